b1_stream: RTL

Registered, parametrised, multi-lane successor to the combinational b1 benchmark function. Applies the b1 truth function independently to LANES 3-bit input lanes per beat, buffers results in a DEPTH-entry output FIFO behind valid/ready handshakes, and keeps a saturating count of po2 "hit" bits. It sits in the benchmark suite as a sequential MCNC-style circuit for FPGA mapping and retiming experiments.

---
 rtl/b1_pkg.sv | 16 +
 rtl/b1_stream_if.sv | 23 ++
 rtl/b1_lane.sv | 18 +
 rtl/b1_stream.sv | 100 ++++++++++
 4 files changed

// File: rtl/b1_pkg.sv
// Shared widths and bit positions for the b1 lane function.
package b1_pkg;

  localparam int B1_IN_W  = 3;
  localparam int B1_OUT_W = 4;

  localparam int PI0 = 0;
  localparam int PI1 = 1;
  localparam int PI2 = 2;

  localparam int PO0 = 0;
  localparam int PO1 = 1;
  localparam int PO2 = 2;
  localparam int PO3 = 3;

endpackage

// File: rtl/b1_stream_if.sv
// Input-beat and output-FIFO handshake bundle for b1_stream.
// valid/ready: a beat transfers on a rising clock edge where valid & ready are both high;
// a producer holding valid keeps its data stable until that edge, and ready never depends on valid.
interface b1_stream_if #(
  parameter int LANES = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [3*LANES-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [4*LANES-1:0]   out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/b1_lane.sv
// Combinational b1 truth function for one 3-bit lane.
module b1_lane
  import b1_pkg::*;
(
  input  logic [B1_IN_W-1:0]  pi,
  output logic [B1_OUT_W-1:0] po
);

  always_comb begin
    po      = '0;
    po[PO0] = pi[PI2];
    po[PO1] = pi[PI0] ^ pi[PI1];
    // po2 fires only for codes 3'b011 and 3'b100
    po[PO2] = (pi[PI0] == pi[PI1]) & (pi[PI2] != pi[PI0]);
    po[PO3] = ~pi[PI2];
  end

endmodule

// File: rtl/b1_stream.sv
// Multi-lane registered b1: lane results pushed into a DEPTH-entry FIFO,
// with a saturating count of po2 hits over accepted beats.
module b1_stream
  import b1_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  b1_stream_if.slave       bus,
  input  logic             clear,
  output logic [CNT_W-1:0] hit_count,
  output logic             hit_sat
);

  localparam int OUT_W = B1_OUT_W * LANES;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int HIT_W = $clog2(LANES + 1);

  logic [OUT_W-1:0] lane_out;
  logic [OUT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             push;
  logic             pop;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    b1_lane u_lane (
      .pi (bus.in_data[B1_IN_W*k +: B1_IN_W]),
      .po (lane_out[B1_OUT_W*k +: B1_OUT_W])
    );
  end

  // in_ready looks only at the registered occupancy, so a full FIFO never
  // accepts even when the head is popped in the same cycle.
  assign bus.in_ready  = (occ < OCC_W'(DEPTH));
  assign bus.out_valid = (occ != '0);
  assign bus.out_data  = mem[rd_ptr];

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= lane_out;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  logic [HIT_W-1:0] hits;
  logic [CNT_W:0]   hit_sum;
  logic [CNT_W-1:0] hit_next;
  logic             sat_next;

  always_comb begin
    hits = '0;
    for (int k = 0; k < LANES; k++) begin
      hits = hits + HIT_W'(lane_out[B1_OUT_W*k + PO2]);
    end
    // one extra bit catches the carry that means the counter would wrap
    hit_sum  = {1'b0, hit_count} + (CNT_W+1)'(hits);
    hit_next = hit_sum[CNT_W] ? {CNT_W{1'b1}} : hit_sum[CNT_W-1:0];
    sat_next = hit_sum[CNT_W] | (hit_next == {CNT_W{1'b1}});
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_count <= '0;
      hit_sat   <= 1'b0;
    end else if (clear) begin
      hit_count <= '0;
      hit_sat   <= 1'b0;
    end else if (push) begin
      hit_count <= hit_next;
      hit_sat   <= hit_sat | sat_next;
    end
  end

endmodule
